// File: rtl/wfifo_pkg.sv
// Shared definitions for the async FIFO write-domain front end:
// skid-buffer state encoding, statistics counter width and a Gray-to-binary
// helper. The helper works on a fixed wide vector; callers zero-extend their
// pointer (zero-extended Gray decodes to the zero-extended binary value).
package wfifo_pkg;

    localparam int STAT_W = 16;
    localparam int GRAY_W = 32;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_t;

    function automatic logic [GRAY_W-1:0] gray2bin(input logic [GRAY_W-1:0] g);
        logic [GRAY_W-1:0] b;
        b[GRAY_W-1] = g[GRAY_W-1];
        for (int i = GRAY_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/wfifo_skid2.sv
// Two-entry skid buffer between the producer stream and the FIFO write port.
// s_ready is registered so the consumer-side stall never reaches the producer
// combinationally.
//
// state | meaning
// ------+------------------------------------------
// EMPTY | no word buffered
// ONE   | head holds the oldest word, presented on m_data
// TWO   | head and tail both hold words, input stalled
module wfifo_skid2
    import wfifo_pkg::*;
#(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    output logic          s_ready,
    output logic          m_valid,
    output logic [DW-1:0] m_data,
    input  logic          m_ready
);

    skid_state_t   state_q, state_d;
    logic [DW-1:0] head_q, head_d;
    logic [DW-1:0] tail_q, tail_d;
    logic          ready_q;
    logic          accept;
    logic          xfer;

    assign accept  = s_valid & ready_q;
    assign m_valid = (state_q != EMPTY);
    assign xfer    = m_valid & m_ready;
    assign m_data  = head_q;
    assign s_ready = ready_q;

    // State, data and ready registers; reset discards any buffered words.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            head_q  <= '0;
            tail_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            ready_q <= (state_d != TWO);
        end
    end

    // Next state and data movement; simultaneous accept+drain in ONE refills head.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d = ONE;
                    head_d  = s_data;
                end
            end
            ONE: begin
                if (accept && !xfer) begin
                    state_d = TWO;
                    tail_d  = s_data;
                end else if (!accept && xfer) begin
                    state_d = EMPTY;
                end else if (accept && xfer) begin
                    head_d  = s_data;
                end
            end
            TWO: begin
                if (xfer) begin
                    state_d = ONE;
                    head_d  = tail_q;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

endmodule

// File: rtl/wfifo_wr_ctrl.sv
// Write-domain front end of the asynchronous FIFO: skid-buffers the producer
// stream into winc/wdata, and derives a registered fill level and almost-full
// flag from the Gray write pointer and synchronized Gray read pointer.
// Optional macro WFIFO_WR_STAT_EN enables the saturating write counter on
// wr_count; without it wr_count is tied to zero.
module wfifo_wr_ctrl
    import wfifo_pkg::*;
#(
    parameter int DSIZE     = 8,
    parameter int ADDRSIZE  = 4,
    parameter int AF_THRESH = 12
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                s_valid,
    input  logic [DSIZE-1:0]    s_data,
    output logic                s_ready,
    output logic                winc,
    output logic [DSIZE-1:0]    wdata,
    input  logic                wfull,
    input  logic [ADDRSIZE:0]   wptr,
    input  logic [ADDRSIZE:0]   wq2_rptr,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                walmost_full,
    output logic [STAT_W-1:0]   wr_count
);

    localparam int PW = ADDRSIZE + 1;
    localparam logic [GRAY_W-1:0] LVL_MASK = GRAY_W'((64'd1 << PW) - 64'd1);

    if (AF_THRESH < 1 || AF_THRESH > (1 << ADDRSIZE)) begin : g_bad_thresh
        $error("wfifo_wr_ctrl: AF_THRESH out of range 1..2**ADDRSIZE");
    end

    logic              m_valid;
    logic [GRAY_W-1:0] wb;
    logic [GRAY_W-1:0] rb;
    logic [GRAY_W-1:0] diff;
    logic [ADDRSIZE:0] level_nxt;
    logic              af_nxt;

    wfifo_skid2 #(
        .DW (DSIZE)
    ) u_skid (
        .clk     (wclk),
        .rst_n   (wrst_n),
        .s_valid (s_valid),
        .s_data  (s_data),
        .s_ready (s_ready),
        .m_valid (m_valid),
        .m_data  (wdata),
        .m_ready (~wfull)
    );

    assign winc = m_valid & ~wfull;

    // Modulo pointer difference; a stale read pointer only overstates the level.
    assign wb        = gray2bin(GRAY_W'(wptr));
    assign rb        = gray2bin(GRAY_W'(wq2_rptr));
    assign diff      = (wb - rb) & LVL_MASK;
    assign level_nxt = diff[ADDRSIZE:0];
    assign af_nxt    = (diff >= GRAY_W'(AF_THRESH));

    // Level and watermark register together so they always agree.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wlevel       <= '0;
            walmost_full <= 1'b0;
        end else begin
            wlevel       <= level_nxt;
            walmost_full <= af_nxt;
        end
    end

`ifdef WFIFO_WR_STAT_EN
    logic [STAT_W-1:0] cnt_q;

    // Count FIFO writes, holding at all-ones instead of wrapping.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            cnt_q <= '0;
        end else if (winc && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign wr_count = cnt_q;
`else
    assign wr_count = '0;
`endif

endmodule

// File: tb/tb_wfifo_wr_ctrl.sv
// Self-checking bench for wfifo_wr_ctrl (DSIZE=8, ADDRSIZE=4, AF_THRESH=12).
// A queue-based reference model tracks buffered words, fill level and write
// count; a negedge process compares every output each cycle, and directed
// tests add literal expectations.
module tb_wfifo_wr_ctrl;

    logic        wclk = 1'b0;
    logic        wrst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic [7:0]  s_data = '0;
    logic        s_ready;
    logic        winc;
    logic [7:0]  wdata;
    logic        wfull = 1'b0;
    logic [4:0]  wptr = '0;
    logic [4:0]  wq2_rptr = '0;
    logic [4:0]  wlevel;
    logic        walmost_full;
    logic [15:0] wr_count;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;

    logic [7:0] mq[$];
    logic       m_ready = 1'b0;
    int         m_level = 0;
    logic       m_af = 1'b0;
    int         m_cnt = 0;

    logic [7:0] obs_data[$];
    int         obs_cyc[$];

    wfifo_wr_ctrl #(
        .DSIZE     (8),
        .ADDRSIZE  (4),
        .AF_THRESH (12)
    ) dut (
        .wclk         (wclk),
        .wrst_n       (wrst_n),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .winc         (winc),
        .wdata        (wdata),
        .wfull        (wfull),
        .wptr         (wptr),
        .wq2_rptr     (wq2_rptr),
        .wlevel       (wlevel),
        .walmost_full (walmost_full),
        .wr_count     (wr_count)
    );

    always #5 wclk = ~wclk;

    function automatic int gray(input int b);
        return b ^ (b >> 1);
    endfunction

    function automatic int g2b(input int g);
        for (int i = 0; i < 32; i++) begin
            if (gray(i) == g) return i;
        end
        return 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    endtask

    // Reference model: a FIFO of buffered words, capacity two.
    always @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            mq.delete();
            m_ready = 1'b0;
            m_level = 0;
            m_af    = 1'b0;
            m_cnt   = 0;
        end else begin
            bit do_w;
            bit do_a;
            int lvl;
            do_w = (mq.size() > 0) && !wfull;
            do_a = s_valid && m_ready;
            if (do_w) begin
                void'(mq.pop_front());
                if (m_cnt < 16'hFFFF) m_cnt++;
            end
            if (do_a) mq.push_back(s_data);
            m_ready = (mq.size() < 2);
            lvl     = (g2b(int'(wptr)) - g2b(int'(wq2_rptr)) + 32) % 32;
            m_level = lvl;
            m_af    = (lvl >= 12);
        end
    end

    always @(posedge wclk) cyc++;

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge wclk) begin
        logic exp_winc;
        int   exp_cnt;
        exp_winc = (mq.size() > 0) && !wfull;
`ifdef WFIFO_WR_STAT_EN
        exp_cnt = m_cnt;
`else
        exp_cnt = 0;
`endif
        chk("s_ready", 32'(s_ready), 32'(m_ready));
        chk("winc", 32'(winc), 32'(exp_winc));
        if (exp_winc) chk("wdata", 32'(wdata), 32'(mq[0]));
        chk("wlevel", 32'(wlevel), 32'(m_level));
        chk("walmost_full", 32'(walmost_full), 32'(m_af));
        chk("wr_count", 32'(wr_count), 32'(exp_cnt));
        if (winc === 1'b1) begin
            obs_data.push_back(wdata);
            obs_cyc.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    task automatic send(input logic [7:0] w);
        bit acc;
        acc = 1'b0;
        s_valid = 1'b1;
        s_data  = w;
        for (int k = 0; k < 60 && !acc; k++) begin
            acc = s_ready;
            step();
        end
        if (!acc) chk("send_timeout", 32'(w), 32'hFFFF_FFFF);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] exp_b[3];

        // 1: reset
        repeat (3) step();
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_winc", 32'(winc), 32'd0);
        chk("rst_wlevel", 32'(wlevel), 32'd0);
        chk("rst_af", 32'(walmost_full), 32'd0);
        wrst_n = 1'b1;
        #1;
        chk("rel_ready_pre", 32'(s_ready), 32'd0);
        step();
        chk("rel_ready_post", 32'(s_ready), 32'd1);

        // 2: streaming 0x01..0x10
        obs_data.delete();
        obs_cyc.delete();
        for (int i = 1; i <= 16; i++) send(8'(i));
        s_valid = 1'b0;
        repeat (6) step();
        chk("stream_count", 32'(obs_data.size()), 32'd16);
        if (obs_data.size() == 16) begin
            for (int i = 0; i < 16; i++) chk("stream_order", 32'(obs_data[i]), 32'(i + 1));
            chk("stream_consecutive", 32'(obs_cyc[15] - obs_cyc[0]), 32'd15);
        end

        // 3: backpressure
        obs_data.delete();
        wfull = 1'b1;
        fork
            begin
                send(8'hA0);
                send(8'hA1);
                send(8'hA2);
                s_valid = 1'b0;
            end
            begin
                repeat (5) step();
                chk("bp_ready", 32'(s_ready), 32'd0);
                chk("bp_winc", 32'(winc), 32'd0);
                chk("bp_head", 32'(wdata), 32'hA0);
                wfull = 1'b0;
            end
        join
        repeat (6) step();
        exp_b[0] = 8'hA0;
        exp_b[1] = 8'hA1;
        exp_b[2] = 8'hA2;
        chk("bp_count", 32'(obs_data.size()), 32'd3);
        if (obs_data.size() == 3)
            for (int i = 0; i < 3; i++) chk("bp_order", 32'(obs_data[i]), 32'(exp_b[i]));

        // 4: level with pointer wrap
        wptr     = 5'(gray(3));
        wq2_rptr = 5'(gray(19));
        step();
        chk("lvl_wrap", 32'(wlevel), 32'd16);
        chk("af_wrap", 32'(walmost_full), 32'd1);
        wptr     = 5'(gray(20));
        wq2_rptr = 5'(gray(9));
        step();
        chk("lvl_11", 32'(wlevel), 32'd11);
        chk("af_11", 32'(walmost_full), 32'd0);

        // 5: watermark edge 11 -> 12 -> 11
        wptr = 5'(gray(21));
        chk("af_hold_pre", 32'(walmost_full), 32'd0);
        step();
        chk("lvl_12", 32'(wlevel), 32'd12);
        chk("af_12", 32'(walmost_full), 32'd1);
        wptr = 5'(gray(20));
        chk("af_hold_pre2", 32'(walmost_full), 32'd1);
        step();
        chk("lvl_back_11", 32'(wlevel), 32'd11);
        chk("af_back_0", 32'(walmost_full), 32'd0);

        // 6: reset with both entries full, then no stale write
        wfull = 1'b1;
        send(8'hB0);
        send(8'hB1);
        s_valid = 1'b1;
        s_data  = 8'hB2;
        chk("two_ready", 32'(s_ready), 32'd0);
        #2;
        wrst_n  = 1'b0;
        wfull   = 1'b0;
        s_valid = 1'b0;
        #1;
        chk("async_ready", 32'(s_ready), 32'd0);
        chk("async_winc", 32'(winc), 32'd0);
        chk("async_lvl", 32'(wlevel), 32'd0);
        chk("async_af", 32'(walmost_full), 32'd0);
        chk("async_cnt", 32'(wr_count), 32'd0);
        obs_data.delete();
        step();
        wrst_n = 1'b1;
        repeat (8) step();
        chk("no_stale", 32'(obs_data.size()), 32'd0);

        // statistics: 20 writes after a clean reset
        for (int i = 0; i < 20; i++) send(8'(8'h40 + i));
        s_valid = 1'b0;
        repeat (6) step();
`ifdef WFIFO_WR_STAT_EN
        chk("stat_20", 32'(wr_count), 32'd20);
`else
        chk("stat_tied", 32'(wr_count), 32'd0);
`endif
        chk("stat_writes", 32'(obs_data.size()), 32'd20);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
